// File: rtl/bcd_time_counter_if.sv
// Bundle of control, set and time/strobe signals between the 1 Hz tick source,
// the time-of-day counter and its display/alarm consumers.
interface bcd_time_counter_if;
    logic       enb;
    logic       run;
    logic       set_req;
    logic [7:0] set_hh;
    logic [7:0] set_mm;
    logic [7:0] set_ss;
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
    logic       min_tick;
    logic       hour_tick;
    logic       day_tick;
    logic       set_ack;
    logic       set_err;

    modport master (
        output enb, run, set_req, set_hh, set_mm, set_ss,
        input  hh, mm, ss, min_tick, hour_tick, day_tick, set_ack, set_err
    );

    modport slave (
        input  enb, run, set_req, set_hh, set_mm, set_ss,
        output hh, mm, ss, min_tick, hour_tick, day_tick, set_ack, set_err
    );
endinterface

// File: rtl/bcd_time_counter.sv
// BCD hh:mm:ss time-of-day register advanced by the 1 Hz strobe, with a range-checked
// synchronous time-set load and single-cycle rollover strobes.
module bcd_time_counter #(
    parameter int HOUR_MAX = 23
) (
    input logic              clk,
    input logic              rst_n,
    bcd_time_counter_if.slave bus
);
    localparam logic [7:0] HOUR_MAX_BCD = {4'(HOUR_MAX / 10), 4'(HOUR_MAX % 10)};

    logic [7:0] hh_q, mm_q, ss_q;
    logic [7:0] hh_nxt, mm_nxt, ss_nxt;
    logic       min_tick_q, hour_tick_q, day_tick_q, set_ack_q, set_err_q;
    logic       ss_wrap, mm_wrap, hh_wrap, tick, set_ok;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign tick    = bus.enb & bus.run;
    assign ss_wrap = (ss_q == 8'h59);
    assign mm_wrap = (mm_q == 8'h59);
    assign hh_wrap = (hh_q == HOUR_MAX_BCD);

    // Carry chain: each pair only moves when every lower pair wraps.
    always_comb begin
        ss_nxt = ss_wrap ? 8'h00 : bcd_inc(ss_q);
        mm_nxt = mm_q;
        hh_nxt = hh_q;
        if (ss_wrap) begin
            mm_nxt = mm_wrap ? 8'h00 : bcd_inc(mm_q);
            if (mm_wrap)
                hh_nxt = hh_wrap ? 8'h00 : bcd_inc(hh_q);
        end
    end

    // Whole-byte compare on hours is only meaningful once both nibbles are decimal.
    assign set_ok = (bus.set_hh[7:4] <= 4'd9) && (bus.set_hh[3:0] <= 4'd9) &&
                    (bus.set_hh <= HOUR_MAX_BCD) &&
                    (bus.set_mm[7:4] <= 4'd5) && (bus.set_mm[3:0] <= 4'd9) &&
                    (bus.set_ss[7:4] <= 4'd5) && (bus.set_ss[3:0] <= 4'd9);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hh_q        <= 8'h00;
            mm_q        <= 8'h00;
            ss_q        <= 8'h00;
            min_tick_q  <= 1'b0;
            hour_tick_q <= 1'b0;
            day_tick_q  <= 1'b0;
            set_ack_q   <= 1'b0;
            set_err_q   <= 1'b0;
        end else begin
            min_tick_q  <= 1'b0;
            hour_tick_q <= 1'b0;
            day_tick_q  <= 1'b0;
            set_ack_q   <= 1'b0;
            set_err_q   <= 1'b0;
            if (bus.set_req) begin
                if (set_ok) begin
                    hh_q      <= bus.set_hh;
                    mm_q      <= bus.set_mm;
                    ss_q      <= bus.set_ss;
                    set_ack_q <= 1'b1;
                end else begin
                    set_err_q <= 1'b1;
                end
            end else if (tick) begin
                hh_q        <= hh_nxt;
                mm_q        <= mm_nxt;
                ss_q        <= ss_nxt;
                min_tick_q  <= ss_wrap;
                hour_tick_q <= ss_wrap & mm_wrap;
                day_tick_q  <= ss_wrap & mm_wrap & hh_wrap;
            end
        end
    end

    assign bus.hh        = hh_q;
    assign bus.mm        = mm_q;
    assign bus.ss        = ss_q;
    assign bus.min_tick  = min_tick_q;
    assign bus.hour_tick = hour_tick_q;
    assign bus.day_tick  = day_tick_q;
    assign bus.set_ack   = set_ack_q;
    assign bus.set_err   = set_err_q;
endmodule
